// File: rtl/combi_pkg.sv
// Shared types and constants for the combined ARM/RISC-V fetch stage and IF/ID register.
package combi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic        valid;
  } ifid_t;

  function automatic ifid_t mk_entry(input logic [31:0] instr, input logic [31:0] pc);
    mk_entry = '{instr: instr, pc: pc, pcplus4: pc + 32'd4, valid: 1'b1};
  endfunction

endpackage

// File: rtl/combi_ifid_buf.sv
// One-entry holding buffer that parks a fetched instruction while decode is stalled.
module combi_ifid_buf
  import combi_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  clear,
  input  ifid_t din,
  output ifid_t dout,
  output logic  valid
);

  ifid_t entry;

  // clear wins so a redirect can never resurrect a wrong-path instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      valid <= 1'b0;
    else if (clear) valid <= 1'b0;
    else if (load)  valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (load) entry <= din;
  end

  assign dout = entry;

endmodule

// File: rtl/combi_fetch.sv
// Fetch stage and IF/ID register: owns PCF, talks to instruction memory with one
// request in flight, and feeds the decoder with instrD, armInD and wasNotFlushedD.
module combi_fetch
  import combi_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic        ARM_AT_RESET = 1'b0,
  parameter logic [31:0] NOP_INSTR    = NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        armD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        armInD,
  output logic        wasNotFlushedD
);

  fetch_state_t state;
  logic [31:0]  pcf_p0;
  logic [31:0]  req_pc_p0;
  logic         accept;
  logic         resp_ok;
  logic         d_adv;
  logic         buf_load;
  logic         buf_clear;
  logic         buf_valid;
  ifid_t        buf_entry;
  ifid_t        resp_entry;
  ifid_t        d_next;
  ifid_t        ifid_p1;
  logic         arm_p1;

  // ---- fetch stage (p0): request issue, PC and FSM ----
  assign imem_req  = !reset && (state == IDLE) && !StallF && !buf_valid;
  assign imem_addr = pcf_p0;
  assign accept    = imem_req && imem_ready;

  // A response arriving together with a redirect belongs to the wrong path.
  assign resp_ok    = (state == WAIT) && imem_rvalid && !PCSrcE;
  assign resp_entry = mk_entry(imem_rdata, req_pc_p0);
  assign d_adv      = !StallD && !FlushD;
  assign buf_load   = resp_ok && !d_adv;
  assign buf_clear  = PCSrcE || (buf_valid && d_adv);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pcf_p0 <= RESET_PC;
    end else begin
      if (PCSrcE)      pcf_p0 <= PCTargetE;
      else if (accept) pcf_p0 <= pcf_p0 + 32'd4;

      case (state)
        IDLE:    if (accept) state <= PCSrcE ? DROP : WAIT;
        WAIT: begin
          if (imem_rvalid) state <= IDLE;
          else if (PCSrcE) state <= DROP;
        end
        DROP:    if (imem_rvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) req_pc_p0 <= pcf_p0;
  end

  combi_ifid_buf u_buf (
    .clk   (clk),
    .reset (reset),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (resp_entry),
    .dout  (buf_entry),
    .valid (buf_valid)
  );

  // Bubbles keep the previous PCs so PCD stays meaningful across stalls/flushes.
  always_comb begin
    d_next = '{instr: NOP_INSTR, pc: ifid_p1.pc, pcplus4: ifid_p1.pcplus4, valid: 1'b0};
    if (buf_valid && !PCSrcE) d_next = buf_entry;
    else if (resp_ok)         d_next = resp_entry;
  end

  // ---- IF/ID register (p1) and mode register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_p1 <= '{instr: NOP_INSTR, pc: 32'd0, pcplus4: 32'd4, valid: 1'b0};
      arm_p1  <= ARM_AT_RESET;
    end else begin
      if (FlushD) begin
        ifid_p1.instr <= NOP_INSTR;
        ifid_p1.valid <= 1'b0;
      end else if (!StallD) begin
        ifid_p1 <= d_next;
      end
      // only a real instruction leaving D may change the mode
      if (ifid_p1.valid && !StallD && !FlushD) arm_p1 <= armD;
    end
  end

  assign instrD         = ifid_p1.instr;
  assign PCD            = ifid_p1.pc;
  assign PCPlus4D       = ifid_p1.pcplus4;
  assign wasNotFlushedD = ifid_p1.valid;
  assign armInD         = arm_p1;

endmodule

// File: tb/tb_combi_fetch.sv
// Scoreboard bench for combi_fetch: directed stimulus pushes expected D-stage
// instructions, a monitor pops and compares them as they appear in decode.
module tb_combi_fetch;

  logic        clk;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE, armD;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrD, PCD, PCPlus4D;
  logic        armInD, wasNotFlushedD;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          lat = 1;
  logic        adv_prev = 1'b0;
  logic [31:0] mem_a;
  exp_t        got;

  combi_fetch #(
    .RESET_PC     (32'h0000_0000),
    .ARM_AT_RESET (1'b0),
    .NOP_INSTR    (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .PCSrcE         (PCSrcE),
    .PCTargetE      (PCTargetE),
    .armD           (armD),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instrD         (instrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D),
    .armInD         (armInD),
    .wasNotFlushedD (wasNotFlushedD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)  return 32'h0050_0093;
    if (a == 32'h18) return 32'hDEAD_BEEF;
    return {a[11:0], 20'h00093};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  // Memory model: answers each accepted request after 'lat' cycles, one beat.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (imem_req && imem_ready && !reset) begin
        mem_a = imem_addr;
        repeat (lat) @(posedge clk);
        #1;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_a);
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  end

  // Monitor: a new D instruction is one that is valid after an edge where D advanced.
  initial begin
    forever begin
      @(negedge clk);
      if (adv_prev && !reset && wasNotFlushedD) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected instrD: got %h at pc %h, expected none", instrD, PCD);
        end else begin
          got = sb.pop_front();
          check("sb instrD", instrD, got.instr);
          check("sb PCD", PCD, got.pc);
          check("sb PCPlus4D", PCPlus4D, got.pc + 32'd4);
        end
      end
      adv_prev = !StallD;
    end
  end

  initial begin
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = 32'h0; armD = 1'b0; imem_ready = 1'b1;
    step(2);
    check("rst imem_req", 32'(imem_req), 32'd0);
    check("rst instrD", instrD, 32'h13);
    check("rst PCD", PCD, 32'd0);
    check("rst PCPlus4D", PCPlus4D, 32'd4);
    check("rst wasNotFlushedD", 32'(wasNotFlushedD), 32'd0);
    check("rst armInD", 32'(armInD), 32'd0);

    // sequential fetch 0,4,8,12 then a stall that buffers 16
    push(32'h0050_0093, 32'h00); push(32'h0040_0093, 32'h04);
    push(32'h0080_0093, 32'h08); push(32'h00C0_0093, 32'h0C);
    push(32'h0100_0093, 32'h10); push(32'h0140_0093, 32'h14);
    reset = 1'b0;
    step(2);
    check("first instrD", instrD, 32'h0050_0093);
    check("first PCD", PCD, 32'd0);
    check("first valid", 32'(wasNotFlushedD), 32'd1);
    step(6);
    StallD = 1'b1;
    step(2);
    check("stall imem_req", 32'(imem_req), 32'd0);
    check("stall instrD held", instrD, 32'h00C0_0093);
    check("stall valid held", 32'(wasNotFlushedD), 32'd1);
    step(1);
    StallD = 1'b0;
    check("buffer full imem_req", 32'(imem_req), 32'd0);
    step(2);
    StallF = 1'b1;

    // redirect while waiting: the 0xDEADBEEF response at 0x18 must be dropped
    step(1);
    StallF = 1'b0; lat = 2;
    push(32'h1000_0093, 32'h100);
    step(1);
    PCSrcE = 1'b1; PCTargetE = 32'h100;
    step(1);
    PCSrcE = 1'b0;
    step(1);
    check("redirect imem_req", 32'(imem_req), 32'd1);
    check("redirect imem_addr", imem_addr, 32'h100);
    check("drop instrD", instrD, 32'h13);
    step(1);
    StallF = 1'b1;

    // flush with stall: bubble loaded, mode untouched
    step(2);
    StallD = 1'b1; FlushD = 1'b1; armD = 1'b1;
    step(1);
    check("flush instrD", instrD, 32'h13);
    check("flush valid", 32'(wasNotFlushedD), 32'd0);
    check("flush PCD kept", PCD, 32'h100);
    check("flush armInD", 32'(armInD), 32'd0);
    FlushD = 1'b0; StallD = 1'b0;
    step(1);
    check("bubble armInD", 32'(armInD), 32'd0);

    // mode change on a real instruction
    armD = 1'b0; StallF = 1'b0; lat = 1;
    push(32'h1040_0093, 32'h104);
    step(1);
    StallF = 1'b1;
    step(1);
    armD = 1'b1;
    step(1);
    armD = 1'b0;
    check("mode armInD set", 32'(armInD), 32'd1);
    step(2);
    check("mode armInD kept", 32'(armInD), 32'd1);

    // async reset in WAIT, then a stray response that must be ignored
    StallF = 1'b0; lat = 2;
    step(1);
    reset = 1'b1; imem_ready = 1'b0;
    #1;
    check("areset imem_req", 32'(imem_req), 32'd0);
    check("areset instrD", instrD, 32'h13);
    check("areset PCD", PCD, 32'd0);
    check("areset PCPlus4D", PCPlus4D, 32'd4);
    check("areset valid", 32'(wasNotFlushedD), 32'd0);
    check("areset armInD", 32'(armInD), 32'd0);
    step(1);
    reset = 1'b0;
    #1;
    check("post-reset imem_req", 32'(imem_req), 32'd1);
    check("post-reset imem_addr", imem_addr, 32'h0);
    step(1);
    check("stray ignored valid", 32'(wasNotFlushedD), 32'd0);
    imem_ready = 1'b1; lat = 1;
    push(32'h0050_0093, 32'h00);
    step(1);
    StallF = 1'b1;

    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
